uart_packet_framer: RTL

//  Upstream stage of the register write path: parses the raw byte stream from the UART receiver into

---
 rtl/uart_packet_framer_pkg.sv | 16 +
 rtl/uart_packet_framer_timer.sv | 26 ++
 rtl/uart_packet_framer.sv | 108 ++++++++++
 3 files changed

// File: rtl/uart_packet_framer_pkg.sv
// Types and constants shared by the UART framer and the register write/read controllers.
package Structures;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic [7:0] Data;
    logic       SoP;
    logic       EoP;
    logic       Valid;
  } UART_PACKET;

endpackage

// File: rtl/uart_packet_framer_timer.sv
// Inter-byte watchdog: counts enabled, uncleared cycles and pulses expire on the TIMEOUT_CYCLES-th one.
module uart_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // A clear in the expiring cycle suppresses the pulse, so a late byte still wins.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count <= '0;
    else if (clear || !enable || expire) count <= '0;
    else                              count <= count + CW'(1);
  end

endmodule

// File: rtl/uart_packet_framer.sv
// Parses SYNC/Dest/Src/Len/payload byte frames from the UART receiver into registered UART_PACKET beats.
module uart_packet_framer
  import Structures::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LENGTH     = 8,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic        ipClk,
  input  logic        ipReset,
  input  logic [7:0]  ipRxData,
  input  logic        ipRxValid,
  output UART_PACKET  opRxStream,
  output logic        opError,
  output logic [15:0] opFrameCount
);

  typedef enum logic [2:0] {IDLE, GET_DEST, GET_SRC, GET_LEN, GET_DATA} state_t;

  localparam logic [7:0] MAX_LEN = 8'(MAX_LENGTH);

  state_t     state, state_next;
  UART_PACKET stream_next;
  logic       error_next;
  logic [15:0] count_next;
  logic [7:0] byte_cnt, byte_cnt_next;
  logic       expire;
  logic       last_beat;

  uart_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk    (ipClk),
    .rst    (ipReset),
    .clear  (ipRxValid),
    .enable (state != IDLE),
    .expire (expire)
  );

  assign last_beat = (byte_cnt == opRxStream.Length - 8'd1);

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state        <= IDLE;
      opRxStream   <= '0;
      opError      <= 1'b0;
      opFrameCount <= '0;
      byte_cnt     <= '0;
    end else begin
      state        <= state_next;
      opRxStream   <= stream_next;
      opError      <= error_next;
      opFrameCount <= count_next;
      byte_cnt     <= byte_cnt_next;
    end
  end

  always_comb begin
    state_next        = state;
    stream_next       = opRxStream;
    stream_next.Valid = 1'b0;
    stream_next.SoP   = 1'b0;
    stream_next.EoP   = 1'b0;
    error_next        = 1'b0;
    count_next        = opFrameCount;
    byte_cnt_next     = byte_cnt;
    if (expire) begin
      // Abandon the frame without an EoP; downstream resyncs on the next SoP.
      error_next = 1'b1;
      state_next = IDLE;
    end else if (ipRxValid) begin
      unique case (state)
        IDLE: begin
          if (ipRxData == SYNC_BYTE) state_next = GET_DEST;
        end
        GET_DEST: begin
          stream_next.Destination = ipRxData;
          state_next              = GET_SRC;
        end
        GET_SRC: begin
          stream_next.Source = ipRxData;
          state_next         = GET_LEN;
        end
        GET_LEN: begin
          stream_next.Length = ipRxData;
          byte_cnt_next      = '0;
          if (ipRxData == 8'd0 || ipRxData > MAX_LEN) begin
            error_next = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = GET_DATA;
          end
        end
        GET_DATA: begin
          stream_next.Valid = 1'b1;
          stream_next.Data  = ipRxData;
          stream_next.SoP   = (byte_cnt == 8'd0);
          stream_next.EoP   = last_beat;
          byte_cnt_next     = byte_cnt + 8'd1;
          if (last_beat) begin
            count_next = opFrameCount + 16'd1;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule
